// File: rtl/fetch_pkg.sv
// Shared widths and helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int HWORD_W     = 16;
  localparam int INSTR_W     = 32;
  localparam int ADDR_W      = 32;
  localparam int INSTR_BYTES = 4;
  localparam int HWORD_BYTES = 2;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [HWORD_W-1:0] hword_t;
  typedef logic [INSTR_W-1:0] instr_t;

  // Redirect targets are word aligned; the low two bits are discarded.
  function automatic addr_t align_word(input addr_t a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hword_fifo.sv
// Halfword buffer between the arbiter return path and decode.
// Single push per cycle, two-entry pop; flush beats push.
module fetch_hword_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  hword_t                 push_data,
  input  logic                   pop2,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output hword_t                 peek0,
  output hword_t                 peek1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  hword_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_p1;

  assign rd_ptr_p1 = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop2) begin
        rd_ptr <= rd_ptr + PTR_W'(2);
      end
      count <= count + CNT_W'(push) - (pop2 ? CNT_W'(2) : CNT_W'(0));
    end
  end

  // Storage needs no reset; pointers define what is live.
  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign peek0 = mem[rd_ptr];
  assign peek1 = mem[rd_ptr_p1];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: streams halfword requests to the arbiter, retries denied
// requests, buffers returns and pairs them into 32-bit instructions for decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_mem_en_o,
  output logic [31:0] instr_mem_addr_o,
  input  logic        instr_mem_en_i,
  input  logic [15:0] mem_value_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Handshakes: arbiter side - a request (instr_mem_en_o) in cycle n is answered
  // in cycle n+1 by instr_mem_en_i (granted, mem_value_i valid) or its absence
  // (denied, re-presented). Decode side - an instruction transfers on a cycle with
  // instr_valid_o & instr_ready_i, except in a redirect cycle.
  addr_t               fetch_pc;
  addr_t               pend_addr;
  logic                pend_valid;
  addr_t               head_pc;

  logic [CNT_W-1:0]    count;
  hword_t              peek0;
  hword_t              peek1;

  logic                push;
  logic                pop2;
  logic                flush;
  logic                credit;
  logic                issue;
  addr_t               retry_addr;
  addr_t               redirect_tgt;
  logic [CNT_W:0]      count_nx;

  always_comb begin
    push         = instr_mem_en_i & pend_valid & ~redirect_i;
    pop2         = instr_valid_o & instr_ready_i & ~redirect_i;
    flush        = redirect_i;
    retry_addr   = (pend_valid && !instr_mem_en_i) ? pend_addr : fetch_pc;
    redirect_tgt = align_word(redirect_pc_i);
    // Reserve room for the halfword this request will return next cycle.
    count_nx     = {1'b0, count} + (CNT_W+1)'(push) - (pop2 ? (CNT_W+1)'(2) : (CNT_W+1)'(0));
    credit       = (count_nx + (CNT_W+1)'(1)) <= (CNT_W+1)'(FIFO_DEPTH);
    issue        = rst_i & credit & ~redirect_i;
  end

  assign instr_mem_en_o   = issue;
  assign instr_mem_addr_o = retry_addr;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc   <= RESET_PC;
      pend_addr  <= RESET_PC;
      pend_valid <= 1'b0;
      head_pc    <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc   <= redirect_tgt;
      head_pc    <= redirect_tgt;
      pend_valid <= 1'b0;
    end else begin
      if (issue) begin
        pend_addr  <= retry_addr;
        pend_valid <= 1'b1;
        fetch_pc   <= retry_addr + addr_t'(HWORD_BYTES);
      end else begin
        // A denied address must not be lost if no request goes out.
        pend_valid <= 1'b0;
        fetch_pc   <= retry_addr;
      end
      if (pop2) begin
        head_pc <= head_pc + addr_t'(INSTR_BYTES);
      end
    end
  end

  fetch_hword_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (mem_value_i),
    .pop2      (pop2),
    .flush     (flush),
    .count     (count),
    .peek0     (peek0),
    .peek1     (peek1)
  );

  assign instr_valid_o = count >= CNT_W'(2);
  assign instr_o       = {peek0, peek1};
  assign instr_pc_o    = head_pc;

endmodule
